// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC request scheduler.
package adc_pkg;

  localparam int ADC_DW          = 8;
  localparam int DEF_MIN_GAP     = 50;
  localparam int DEF_TIMEOUT_CYC = 2000;
  localparam int GAP_CW          = 10;
  localparam int WDOG_W          = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    DELIVER   = 3'd3,
    GAP       = 3'd4
  } sched_state_e;

endpackage

// File: rtl/adc_req_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  logic [IW-1:0] cand;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'(wrap_idx(int'(ptr_i), i));
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_req_scheduler.sv
// Round-robin scheduler sharing one serial ADC engine among NUM_REQ clients.
// Optional conversion watchdog enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_req_scheduler
  import adc_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MIN_GAP     = DEF_MIN_GAP,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              CLK_50M,
  input  logic              RST,
  input  logic [NUM_REQ-1:0] req,
  output logic              conv_start,
  input  logic              conv_done,
  input  logic [ADC_DW-1:0] conv_data,
  output logic [NUM_REQ-1:0] ack,
  output logic [ADC_DW-1:0] rd_data,
  output logic              rd_err,
  output logic [ADC_DW-1:0] last_sample,
  output logic              busy
);

  localparam int IW = $clog2(NUM_REQ);

  sched_state_e       state_q, state_d;
  logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [GAP_CW-1:0]  gap_cnt_q, gap_cnt_d;
  logic               conv_start_q, conv_start_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [ADC_DW-1:0]  rd_data_q, rd_data_d;
  logic [ADC_DW-1:0]  last_sample_q, last_sample_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;

`ifdef ADC_SCHED_TIMEOUT_EN
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               rd_err_q, rd_err_d;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Outputs are registered, so ack/rd_data are computed on the edge that leaves WAIT_DONE
  // and are therefore visible during the DELIVER cycle.
  always_comb begin
    state_d       = state_q;
    gnt_idx_d     = gnt_idx_q;
    gnt_oh_d      = gnt_oh_q;
    rr_ptr_d      = rr_ptr_q;
    gap_cnt_d     = '0;
    conv_start_d  = 1'b0;
    ack_d         = '0;
    rd_data_d     = '0;
    last_sample_d = last_sample_q;
`ifdef ADC_SCHED_TIMEOUT_EN
    wdog_d        = '0;
    rd_err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          gnt_idx_d    = arb_idx;
          gnt_oh_d     = arb_gnt;
          conv_start_d = 1'b1;
          state_d      = START;
        end
      end
      START: begin
`ifdef ADC_SCHED_TIMEOUT_EN
        wdog_d  = WDOG_W'(1);
`endif
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
`ifdef ADC_SCHED_TIMEOUT_EN
        wdog_d = wdog_q + WDOG_W'(1);
`endif
        if (conv_done) begin
          last_sample_d = conv_data;
          ack_d         = gnt_oh_q & req;
          rd_data_d     = (|(gnt_oh_q & req)) ? conv_data : '0;
          state_d       = DELIVER;
        end
`ifdef ADC_SCHED_TIMEOUT_EN
        else if (wdog_q == WDOG_W'(TIMEOUT_CYC)) begin
          ack_d    = gnt_oh_q & req;
          rd_err_d = |(gnt_oh_q & req);
          state_d  = DELIVER;
        end
`endif
      end
      DELIVER: begin
        rr_ptr_d = (gnt_idx_q == IW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IW'(1);
        state_d  = GAP;
      end
      GAP: begin
        if (gap_cnt_q == GAP_CW'(MIN_GAP - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q       <= IDLE;
      gnt_idx_q     <= '0;
      gnt_oh_q      <= '0;
      rr_ptr_q      <= '0;
      gap_cnt_q     <= '0;
      conv_start_q  <= 1'b0;
      ack_q         <= '0;
      rd_data_q     <= '0;
      last_sample_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_idx_q     <= gnt_idx_d;
      gnt_oh_q      <= gnt_oh_d;
      rr_ptr_q      <= rr_ptr_d;
      gap_cnt_q     <= gap_cnt_d;
      conv_start_q  <= conv_start_d;
      ack_q         <= ack_d;
      rd_data_q     <= rd_data_d;
      last_sample_q <= last_sample_d;
      busy_q        <= busy_d;
    end
  end

`ifdef ADC_SCHED_TIMEOUT_EN
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      wdog_q   <= '0;
      rd_err_q <= 1'b0;
    end else begin
      wdog_q   <= wdog_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign rd_err = rd_err_q;
`else
  assign rd_err = 1'b0;
`endif

  assign conv_start  = conv_start_q;
  assign ack         = ack_q;
  assign rd_data     = rd_data_q;
  assign last_sample = last_sample_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_adc_req_scheduler.sv
// Directed self-checking bench for adc_req_scheduler (3 clients, MIN_GAP = 50).
module tb_adc_req_scheduler;

  localparam int NumReq     = 3;
  localparam int MinGap     = 50;
  localparam int TimeoutCyc = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       convStart;
  logic       convDone;
  logic [7:0] convData;
  logic [2:0] ack;
  logic [7:0] rdData;
  logic       rdErr;
  logic [7:0] lastSample;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  adc_req_scheduler #(
    .NUM_REQ     (NumReq),
    .MIN_GAP     (MinGap),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .CLK_50M     (clk),
    .RST         (rst),
    .req         (req),
    .conv_start  (convStart),
    .conv_done   (convDone),
    .conv_data   (convData),
    .ack         (ack),
    .rd_data     (rdData),
    .rd_err      (rdErr),
    .last_sample (lastSample),
    .busy        (busy)
  );

  // 10-unit clock; cyc numbers the cycle that follows each rising edge
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single-cycle engine completion; returns on the negedge where the ack cycle is visible
  task automatic pulse_done(input logic [7:0] d);
    convDone = 1'b1;
    convData = d;
    @(negedge clk);
    convDone = 1'b0;
    convData = 8'h00;
  endtask

  task automatic wait_start(output bit seen, output int at);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (convStart === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b000; convDone = 1'b0; convData = 8'h00;
    idle(3);
    checks++; if (convStart !== 1'b0) begin errors++; $display("[TB] FAIL reset_conv_start: got %b expected 0", convStart); end
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 000", ack); end
    checks++; if (rdData !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rdData); end
    checks++; if (rdErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_err: got %b expected 0", rdErr); end
    checks++; if (lastSample !== 8'h00) begin errors++; $display("[TB] FAIL reset_last_sample: got %h expected 00", lastSample); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single_client();
    int k;
    bit done;
    req = 3'b001;
    @(negedge clk);
    checks++; if (convStart !== 1'b1) begin errors++; $display("[TB] FAIL single_start_latency: got %b expected 1", convStart); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_start: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (convStart !== 1'b0) begin errors++; $display("[TB] FAIL single_start_width: got %b expected 0", convStart); end
    idle(39);
    pulse_done(8'hA5);
    checks++; if (ack !== 3'b001) begin errors++; $display("[TB] FAIL single_ack: got %b expected 001", ack); end
    checks++; if (rdData !== 8'hA5) begin errors++; $display("[TB] FAIL single_rd_data: got %h expected a5", rdData); end
    checks++; if (lastSample !== 8'hA5) begin errors++; $display("[TB] FAIL single_last_sample: got %h expected a5", lastSample); end
    checks++; if (rdErr !== 1'b0) begin errors++; $display("[TB] FAIL single_rd_err: got %b expected 0", rdErr); end
    req = 3'b000;
    @(negedge clk);
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL single_ack_width: got %b expected 000", ack); end
    k = 1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (busy === 1'b0) done = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    checks++; if (k !== MinGap + 1) begin errors++; $display("[TB] FAIL single_busy_fall: got %0d cycles expected %0d", k, MinGap + 1); end
  endtask

  task automatic test_round_robin();
    logic [2:0] expAck [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [7:0] dat    [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
    bit seen;
    bit ok;
    int at;
    int prevAt;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    req = 3'b111;
    prevAt = 0;
    for (int i = 0; i < 4; i++) begin
      wait_start(seen, at);
      checks++; if (!seen) begin errors++; $display("[TB] FAIL rr_start_%0d: got no conv_start expected pulse", i); end
      if (i > 0) begin
        checks++; if (at - prevAt !== MinGap + 6) begin errors++; $display("[TB] FAIL rr_spacing_%0d: got %0d expected %0d", i, at - prevAt, MinGap + 6); end
      end
      prevAt = at;
      idle(3);
      pulse_done(dat[i]);
      checks++; if (ack !== expAck[i]) begin errors++; $display("[TB] FAIL rr_ack_%0d: got %b expected %b", i, ack, expAck[i]); end
      checks++; if (rdData !== dat[i]) begin errors++; $display("[TB] FAIL rr_data_%0d: got %h expected %h", i, rdData, dat[i]); end
    end
    req = 3'b000;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_idle: got busy expected idle"); end
  endtask

  task automatic test_drop_during_wait();
    bit seen;
    bit ok;
    int at;
    req = 3'b010;
    wait_start(seen, at);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL drop_start: got no conv_start expected pulse"); end
    idle(2);
    req = 3'b000;
    idle(1);
    pulse_done(8'h3C);
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL drop_no_ack: got %b expected 000", ack); end
    checks++; if (lastSample !== 8'h3C) begin errors++; $display("[TB] FAIL drop_last_sample: got %h expected 3c", lastSample); end
    wait_idle(ok);
    req = 3'b111;
    wait_start(seen, at);
    idle(1);
    pulse_done(8'h11);
    checks++; if (ack !== 3'b100) begin errors++; $display("[TB] FAIL drop_ptr_advance: got %b expected 100", ack); end
    checks++; if (rdData !== 8'h11) begin errors++; $display("[TB] FAIL drop_next_data: got %h expected 11", rdData); end
    req = 3'b000;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL drop_idle: got busy expected idle"); end
  endtask

  task automatic test_spurious_done();
    pulse_done(8'hFF);
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL spurious_ack: got %b expected 000", ack); end
    checks++; if (lastSample !== 8'h11) begin errors++; $display("[TB] FAIL spurious_last_sample: got %h expected 11", lastSample); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL spurious_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (convStart !== 1'b0) begin errors++; $display("[TB] FAIL spurious_start: got %b expected 0", convStart); end
  endtask

`ifdef ADC_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    bit hit;
    bit ok;
    int at;
    int ackAt;
    req = 3'b001;
    wait_start(seen, at);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL timeout_start: got no conv_start expected pulse"); end
    hit = 1'b0;
    ackAt = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (ack !== 3'b000) begin
        hit = 1'b1;
        ackAt = cyc;
      end
    end
    checks++; if (ackAt - at !== TimeoutCyc + 1) begin errors++; $display("[TB] FAIL timeout_latency: got %0d expected %0d", ackAt - at, TimeoutCyc + 1); end
    checks++; if (ack !== 3'b001) begin errors++; $display("[TB] FAIL timeout_ack: got %b expected 001", ack); end
    checks++; if (rdErr !== 1'b1) begin errors++; $display("[TB] FAIL timeout_rd_err: got %b expected 1", rdErr); end
    checks++; if (rdData !== 8'h00) begin errors++; $display("[TB] FAIL timeout_rd_data: got %h expected 00", rdData); end
    checks++; if (lastSample !== 8'h11) begin errors++; $display("[TB] FAIL timeout_last_sample: got %h expected 11", lastSample); end
    req = 3'b000;
    wait_idle(ok);
  endtask
`endif

  task automatic test_reset_mid_op();
    bit seen;
    int at;
    req = 3'b001;
    wait_start(seen, at);
    checks++; if (!seen) begin errors++; $display("[TB] FAIL midrst_start: got no conv_start expected pulse"); end
    idle(2);
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (lastSample !== 8'h00) begin errors++; $display("[TB] FAIL midrst_last_sample: got %h expected 00", lastSample); end
    checks++; if (ack !== 3'b000 || rdData !== 8'h00 || rdErr !== 1'b0 || convStart !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got ack=%b rd_data=%h rd_err=%b start=%b expected all zero", ack, rdData, rdErr, convStart);
    end
    rst = 1'b0;
    pulse_done(8'h77);
    checks++; if (ack !== 3'b000) begin errors++; $display("[TB] FAIL midrst_late_ack: got %b expected 000", ack); end
    checks++; if (lastSample !== 8'h00) begin errors++; $display("[TB] FAIL midrst_late_sample: got %h expected 00", lastSample); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_late_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_client();
    test_round_robin();
    test_drop_during_wait();
    test_spurious_done();
`ifdef ADC_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_req_scheduler.md
# adc_req_scheduler

Shares the single serial 8-bit ADC read engine (CS/CLK/DATA converter front end) among up to NUM_REQ client blocks: voltage display, threshold alarm, logger. It grants requests round-robin, issues one conversion per grant, returns the result to the winning client, and enforces a minimum idle gap between conversions. It sits between the clients and the ADC engine, which exposes a start/done handshake.

## Interface
Parameters:
- NUM_REQ, 3: number of requesting clients, 2..8.
- MIN_GAP, 50: idle cycles forced after each conversion before the next start, 1..1023.
- TIMEOUT_CYC, 2000: cycles from conv_start to abort. Used only with ADC_SCHED_TIMEOUT_EN.

Ports:
- CLK_50M  in  1  single system clock. One clock domain; reset is synchronous and active-high.
- RST  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per client. Held high until ack.
- conv_start  out  1  one-cycle pulse telling the engine to begin a read.
- conv_done  in  1  one-cycle pulse from the engine; conv_data is valid in the same cycle.
- conv_data  in  8  converted sample.
- ack  out  NUM_REQ  one-hot, one-cycle pulse to the served client.
- rd_data  out  8  sample for the acked client. Valid only while ack is nonzero.
- rd_err  out  1  high with ack when the conversion was aborted. Constant 0 without the macro.
- last_sample  out  8  most recent successful sample, held between conversions.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, WAIT_DONE, DELIVER, GAP.
- IDLE:
  - If any req bit is high, pick the winner: the first set bit at or above rr_ptr, wrapping modulo NUM_REQ.
  - Latch the winner's index in gnt_idx, then go to START.
- START: conv_start = 1 for exactly this one cycle; go to WAIT_DONE.
- WAIT_DONE:
  - On conv_done, capture conv_data into the sample register, load last_sample, and go to DELIVER.
  - conv_done seen in any other state is ignored.
- DELIVER:
  - If req[gnt_idx] is still high, pulse ack[gnt_idx] with rd_data = sample.
  - If the client dropped req, issue no ack; last_sample is still updated.
  - rr_ptr <= gnt_idx+1, wrapping to 0 at NUM_REQ. Go to GAP.
- GAP: count MIN_GAP cycles, then return to IDLE. Requests arriving during GAP are held and arbitrated in IDLE.
- Arbitration happens only in IDLE. The winner is latched; requests that rise or fall later do not change gnt_idx.
- Out-of-range req bits do not exist. NUM_REQ sets the port width exactly.

## Timing
- Reset values: state = IDLE, conv_start = 0, ack = 0, rd_data = 0x00, rd_err = 0, last_sample = 0x00, busy = 0, rr_ptr = 0, gap counter = 0.
- All outputs are registered.
- req first seen high in IDLE at cycle t → conv_start high at t+1.
- conv_done at cycle d → ack/rd_data at d+1 → next conv_start no earlier than d+2+MIN_GAP+1.
- Minimum spacing between conv_start pulses is 4 + MIN_GAP cycles plus the engine's conversion time.
- Simultaneous requests: exactly one ack per conversion. No client is skipped twice in a row while requesting.
- Reset mid-operation:
  - Return to IDLE and clear all outputs on the next edge.
  - A late conv_done from the engine after reset is ignored.

## Configuration
- ADC_SCHED_TIMEOUT_EN defined:
  - A 16-bit watchdog counts from START.
  - Reaching TIMEOUT_CYC in WAIT_DONE forces DELIVER with rd_data = 0x00 and rd_err = 1 alongside ack.
  - last_sample is not updated on a timeout.
- Not defined: no counter is generated, WAIT_DONE waits indefinitely, and rd_err is tied to 0.

## Structure
- Shared package adc_pkg holds:
  - the state enum (IDLE = 0, START = 1, WAIT_DONE = 2, DELIVER = 3, GAP = 4);
  - the ADC data width constant ADC_DW = 8;
  - the default MIN_GAP and TIMEOUT_CYC values.
- One sub-module, rr_arbiter: combinational round-robin pick of (req, rr_ptr) → one-hot winner plus index. The pointer register stays in the parent.

## Test plan
- Single client: req[0] high; engine returns done 40 cycles after start with data 0xA5 → ack = 3'b001 for one cycle, rd_data = 0xA5, last_sample = 0xA5, busy falls MIN_GAP+1 cycles later.
- All three clients request together from reset → acks in order 001, 010, 100, then 001 again if still requesting. conv_start pulses are ≥ MIN_GAP+4 cycles apart.
- req[1] drops during WAIT_DONE; done data = 0x3C → no ack, last_sample = 0x3C, rr_ptr advances to 2.
- Spurious conv_done in IDLE with data 0xFF → no ack, last_sample unchanged.
- RST asserted during WAIT_DONE, then conv_done on the following cycle → all outputs return to reset values and the done pulse is ignored.
- With ADC_SCHED_TIMEOUT_EN and TIMEOUT_CYC = 100, conv_done never arrives → ack and rd_err = 1 with rd_data = 0x00 at start+101; last_sample unchanged.
